seq_detect_ctrl: RTL and testbench

Word-fed controller for the Moore serial sequence detector. It accepts parallel words over a valid/ready handshake, serializes them MSB-first onto the detector input, and runs a configurable Moore pattern matcher (1–3 bits, overlapping or not). Per word it reports the match count and keeps a saturating running total. It sits between a parallel producer and the serial detection path, owning sequencing, configuration latching and match accounting.

---
 rtl/seq_detect_ctrl_if.sv | 21 ++
 rtl/seq_detect_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_if.sv
// Word handshake between a parallel producer (master) and the sequence detector
// controller (slave).
interface seq_detect_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Word-fed Moore sequence detector: serializes accepted words MSB-first and
// counts matches of a latched 1..3-bit pattern per word and in a saturating total.
module seq_detect_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        cfg_pattern,
    input  logic [1:0]        cfg_len,
    input  logic              cfg_overlap,
    seq_detect_ctrl_if.slave  bus,
    input  logic              clr_count,
    output logic              x_out,
    output logic              z,
    output logic              word_done,
    output logic [CNT_W-1:0]  word_matches,
    output logic [CNT_W-1:0]  total_matches
);

    localparam int BC_W = $clog2(WIDTH);

    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(WIDTH - 1);
    localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0]  BC_ZERO  = BC_W'(0);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]       pat_q, pat_d;
    logic [1:0]       len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [2:0]       hist_q, hist_d;
    logic [1:0]       fill_q, fill_d;
    logic             in_ready_q, in_ready_d;
    logic             x_out_q, x_out_d;
    logic             z_q, z_d;
    logic             word_done_q, word_done_d;
    logic [CNT_W-1:0] word_matches_q, word_matches_d;
    logic [CNT_W-1:0] total_q, total_d;

    logic [2:0]       hist_nxt_s;
    logic [1:0]       fill_inc_s;
    logic             match_s;
    logic [CNT_W-1:0] total_upd_s;

    // A length of zero selects the full three-bit pattern.
    function automatic logic [1:0] eff_len(input logic [1:0] len);
        logic [1:0] r;
        if (len == 2'd0) begin
            r = 2'd3;
        end else begin
            r = len;
        end
        return r;
    endfunction

    function automatic logic pattern_hit(input logic [2:0] h,
                                         input logic [2:0] pat,
                                         input logic [1:0] len);
        logic hit;
        case (len)
            2'd1:    hit = (h[0] == pat[0]);
            2'd2:    hit = (h[1:0] == pat[1:0]);
            default: hit = (h == pat);
        endcase
        return hit;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = CNT_MAX;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        pat_d          = pat_q;
        len_d          = len_q;
        ovl_d          = ovl_q;
        hist_d         = hist_q;
        fill_d         = fill_q;
        word_matches_d = word_matches_q;
        total_upd_s    = total_q;
        z_d            = 1'b0;
        match_s        = 1'b0;

        // x_out_q is exactly the bit being sampled on a SHIFT edge.
        hist_nxt_s = {hist_q[1:0], x_out_q};
        if (fill_q == 2'd3) begin
            fill_inc_s = 2'd3;
        end else begin
            fill_inc_s = fill_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d        = SHIFT;
                    shreg_d        = bus.in_data;
                    pat_d          = cfg_pattern;
                    len_d          = eff_len(cfg_len);
                    ovl_d          = cfg_overlap;
                    bit_cnt_d      = BC_LAST;
                    word_matches_d = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                match_s   = pattern_hit(hist_nxt_s, pat_q, len_q) && (fill_inc_s >= len_q);
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                hist_d    = hist_nxt_s;
                bit_cnt_d = bit_cnt_q - BC_ONE;
                if (match_s && !ovl_q) begin
                    fill_d = 2'd0;
                end else begin
                    fill_d = fill_inc_s;
                end
                // word_matches cannot wrap: CNT_W is sized to hold WIDTH.
                if (match_s) begin
                    z_d            = 1'b1;
                    word_matches_d = word_matches_q + CNT_ONE;
                    total_upd_s    = sat_inc(total_q);
                end else begin
                    z_d = 1'b0;
                end
                if (bit_cnt_q == BC_ZERO) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear has priority over a coincident match.
        if (clr_count) begin
            total_d = CNT_ZERO;
        end else begin
            total_d = total_upd_s;
        end

        in_ready_d  = (state_d == IDLE);
        word_done_d = (state_d == DONE);
        if (state_d == SHIFT) begin
            x_out_d = shreg_d[WIDTH-1];
        end else begin
            x_out_d = 1'b0;
        end
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            shreg_q        <= {WIDTH{1'b0}};
            bit_cnt_q      <= BC_ZERO;
            pat_q          <= 3'd0;
            len_q          <= 2'd3;
            ovl_q          <= 1'b0;
            hist_q         <= 3'd0;
            fill_q         <= 2'd0;
            in_ready_q     <= 1'b1;
            x_out_q        <= 1'b0;
            z_q            <= 1'b0;
            word_done_q    <= 1'b0;
            word_matches_q <= CNT_ZERO;
            total_q        <= CNT_ZERO;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            pat_q          <= pat_d;
            len_q          <= len_d;
            ovl_q          <= ovl_d;
            hist_q         <= hist_d;
            fill_q         <= fill_d;
            in_ready_q     <= in_ready_d;
            x_out_q        <= x_out_d;
            z_q            <= z_d;
            word_done_q    <= word_done_d;
            word_matches_q <= word_matches_d;
            total_q        <= total_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign x_out          = x_out_q;
    assign z              = z_q;
    assign word_done      = word_done_q;
    assign word_matches   = word_matches_q;
    assign total_matches  = total_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: table vectors, hand-written corner
// sequences and random words against a queue-based reference model.
module tb_seq_detect_ctrl;

    localparam int W = 8;

    logic       clk;
    logic       reset;
    logic [2:0] cfg_pattern;
    logic [1:0] cfg_len;
    logic       cfg_overlap;
    logic       clr_count;
    logic       x_out;
    logic       z;
    logic       word_done;
    logic [7:0] word_matches;
    logic [7:0] total_matches;

    seq_detect_ctrl_if #(.WIDTH(W)) bus ();

    seq_detect_ctrl #(.WIDTH(W), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_overlap   (cfg_overlap),
        .bus           (bus),
        .clr_count     (clr_count),
        .x_out         (x_out),
        .z             (z),
        .word_done     (word_done),
        .word_matches  (word_matches),
        .total_matches (total_matches)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits received since the last restart, newest at the back.
    bit         mq[$];
    int         m_total;
    logic [2:0] m_pat;
    int         m_len;
    logic       m_ovl;

    int cyc = 0;
    int accepts[$];

    // Record the cycle number of every handshake.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) accepts.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_bit(input logic b);
        logic hit;
        mq.push_back(b);
        if (mq.size() > 3) void'(mq.pop_front());
        hit = (mq.size() >= m_len);
        if (hit) begin
            for (int k = 0; k < m_len; k++) begin
                if (mq[mq.size() - 1 - k] != m_pat[k]) hit = 1'b0;
            end
        end
        if (hit && !m_ovl) mq.delete();
        return hit;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        clr_count = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mq.delete();
        m_total = 0;
        @(negedge clk);
    endtask

    // Send one word and check every cycle from accept to the following IDLE cycle.
    task automatic run_word(input logic [7:0] w, input logic [2:0] pat, input logic [1:0] len,
                            input logic ovl, input int clr_bit, input logic keep_valid,
                            output logic [7:0] zmask, output logic [7:0] wm);
        logic [7:0] exp_mask;
        int         exp_cnt;
        int         k;
        logic       m;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", bus.in_ready, 32'd1);
        bus.in_data  = w;
        cfg_pattern  = pat;
        cfg_len      = len;
        cfg_overlap  = ovl;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_valid) bus.in_valid = 1'b0;
        cfg_pattern = 3'($urandom);
        cfg_len     = 2'($urandom);
        cfg_overlap = 1'($urandom);
        bus.in_data = 8'($urandom);
        m_pat = pat;
        m_len = (len == 2'd0) ? 3 : int'(len);
        m_ovl = ovl;
        exp_mask = 8'd0;
        exp_cnt  = 0;
        zmask    = 8'd0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("x_out", x_out, 32'(w[W-1-i]));
            chk("ready_busy", bus.in_ready, 32'd0);
            chk("done_busy", word_done, 32'd0);
            chk("total", total_matches, 32'(m_total));
            if (i == 0) begin
                chk("z_first", z, 32'd0);
            end else begin
                chk("z", z, 32'(exp_mask[i-1]));
                zmask[i-1] = z;
            end
            if (i == clr_bit) clr_count = 1'b1;
            m = model_bit(w[W-1-i]);
            exp_mask[i] = m;
            exp_cnt += int'(m);
            if (i == clr_bit) m_total = 0;
            else if (m && m_total < 255) m_total++;
            @(posedge clk);
            #1;
            clr_count = 1'b0;
        end
        @(negedge clk);
        chk("z_last", z, 32'(exp_mask[W-1]));
        zmask[W-1] = z;
        chk("word_done", word_done, 32'd1);
        chk("word_matches", word_matches, 32'(exp_cnt));
        chk("total_done", total_matches, 32'(m_total));
        chk("x_out_done", x_out, 32'd0);
        chk("ready_done", bus.in_ready, 32'd0);
        @(negedge clk);
        chk("ready_idle", bus.in_ready, 32'd1);
        chk("done_idle", word_done, 32'd0);
        chk("z_idle", z, 32'd0);
        chk("x_out_idle", x_out, 32'd0);
        chk("wm_hold", word_matches, 32'(exp_cnt));
        wm = word_matches;
    endtask

    typedef struct {
        logic [2:0] pat;
        logic [1:0] len;
        logic       ovl;
        logic [7:0] word;
        logic [7:0] mask;
        logic [7:0] cnt;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] zm;
    logic [7:0] wm;

    initial begin
        // z mask bit i = match when word bit i (0 = MSB) is sampled.
        tbl[0] = '{3'b111, 2'd3, 1'b1, 8'b0111_1100, 8'h38, 8'd3};
        tbl[1] = '{3'b111, 2'd3, 1'b0, 8'b0111_1100, 8'h08, 8'd1};
        tbl[2] = '{3'b101, 2'd3, 1'b1, 8'b1010_1010, 8'h54, 8'd3};
        tbl[3] = '{3'b101, 2'd3, 1'b0, 8'b1010_1010, 8'h44, 8'd2};
        tbl[4] = '{3'b001, 2'd1, 1'b1, 8'hA5,        8'hA5, 8'd4};
        tbl[5] = '{3'b010, 2'd2, 1'b1, 8'b1100_1100, 8'h44, 8'd2};
        tbl[6] = '{3'b111, 2'd0, 1'b1, 8'hFF,        8'hFC, 8'd6};
        tbl[7] = '{3'b111, 2'd0, 1'b0, 8'hFF,        8'h24, 8'd2};

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        cfg_pattern  = 3'd0;
        cfg_len      = 2'd0;
        cfg_overlap  = 1'b0;
        clr_count    = 1'b0;
        mq.delete();
        m_total = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.in_ready, 32'd1);
        chk("rst_x_out", x_out, 32'd0);
        chk("rst_z", z, 32'd0);
        chk("rst_word_done", word_done, 32'd0);
        chk("rst_word_matches", word_matches, 32'd0);
        chk("rst_total", total_matches, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            do_reset();
            run_word(tbl[t].word, tbl[t].pat, tbl[t].len, tbl[t].ovl, -1, 1'b0, zm, wm);
            chk($sformatf("tbl%0d_zmask", t), zm, 32'(tbl[t].mask));
            chk($sformatf("tbl%0d_count", t), wm, 32'(tbl[t].cnt));
        end

        // Pattern spanning a word boundary.
        do_reset();
        run_word(8'b0000_0011, 3'b111, 2'd3, 1'b1, -1, 1'b0, zm, wm);
        chk("cross_w1_count", wm, 32'd0);
        run_word(8'b1000_0000, 3'b111, 2'd3, 1'b1, -1, 1'b0, zm, wm);
        chk("cross_w2_count", wm, 32'd1);
        chk("cross_w2_zmask", zm, 32'h01);

        // Saturation, then clear on a match edge.
        do_reset();
        for (int n = 0; n < 32; n++) run_word(8'hFF, 3'b001, 2'd1, 1'b1, -1, 1'b0, zm, wm);
        chk("sat_total", total_matches, 32'd255);
        run_word(8'hFF, 3'b001, 2'd1, 1'b1, 3, 1'b0, zm, wm);
        chk("clr_total", total_matches, 32'd4);
        chk("clr_word_matches", wm, 32'd8);

        // Reset during bit 4, then no match from stale history.
        do_reset();
        cfg_pattern  = 3'b111;
        cfg_len      = 2'd3;
        cfg_overlap  = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_total_before", total_matches, 32'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", bus.in_ready, 32'd1);
        chk("mid_rst_x_out", x_out, 32'd0);
        chk("mid_rst_z", z, 32'd0);
        chk("mid_rst_done", word_done, 32'd0);
        chk("mid_rst_wm", word_matches, 32'd0);
        chk("mid_rst_total", total_matches, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        m_total = 0;
        @(negedge clk);
        chk("post_rst_ready", bus.in_ready, 32'd1);
        run_word(8'h80, 3'b111, 2'd3, 1'b1, -1, 1'b0, zm, wm);
        chk("post_rst_count", wm, 32'd0);
        chk("post_rst_zmask", zm, 32'd0);

        // Backpressure: in_valid held high across three words.
        do_reset();
        accepts.delete();
        run_word(8'h7C, 3'b111, 2'd3, 1'b1, -1, 1'b1, zm, wm);
        run_word(8'hAA, 3'b101, 2'd3, 1'b1, -1, 1'b1, zm, wm);
        run_word(8'h03, 3'b111, 2'd3, 1'b1, -1, 1'b0, zm, wm);
        repeat (3) @(negedge clk);
        chk("bp_accepts", accepts.size(), 32'd3);
        if (accepts.size() == 3) begin
            chk("bp_gap1", accepts[1] - accepts[0], 32'(W + 2));
            chk("bp_gap2", accepts[2] - accepts[1], 32'(W + 2));
        end

        // Random words against the reference model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            run_word(8'($urandom), 3'($urandom), 2'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                     1'($urandom), zm, wm);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rand_final_total", total_matches, 32'(m_total));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
